maze_path_tracker: RTL
======================

# maze_path_tracker

Upstream producer of the 9-bit `path_data` word consumed by the VGA maze renderer. It tracks a player cursor on a maze grid of up to 3×3 cells and marks every visited cell. The cursor is moved by four push-button inputs, which are synchronized and edge-detected. The block also reports the cursor position, an accepted-move count and a goal-reached flag.

## Interface
Parameters:
- `MAX_DIM`, default 3: maximum grid dimension per axis; `path_data` width is `MAX_DIM*MAX_DIM`.
- `CNT_W`, default 8: width of `move_count`.

Ports:
- `clk`  in  1: the single system clock; every flop is clocked on its rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`  in  1 each: raw asynchronous, debounced buttons; active-high.
- `clear`  in  1: raw asynchronous request to restart the maze; active-high.
- `maze_width`, `maze_height`  in  3 each: grid size. Sampled only in S_INIT.
- `path_data`  out  9: visited map. Bit index is `3*x + y`, which matches the renderer's `path_array[x][y]` slicing.
- `cur_x`, `cur_y`  out  2 each: current cursor cell. x = column, y = row, with y=0 as the top row.
- `move_count`  out  CNT_W: number of accepted moves; saturates at 255.
- `done`  out  1: high while the cursor sits on the goal cell `(w-1, h-1)`.

## Operation
- **Input conditioning.** Each button and `clear` passes through a 2-flop synchronizer and a third flop for edge detection. A pulse `*_evt` is produced on the rising edge of the synchronized level.
- **Dimension clamp.** Applied on sampling: a value of 0 is treated as 1; values greater than 3 are treated as 3. The clamped results are held in `w_reg` and `h_reg`.
- **FSM states:** S_INIT, S_TRACK, S_DONE.
  - **S_INIT** lasts one cycle. It latches `w_reg`/`h_reg`, sets `path_data = 9'b1` (cell (0,0) visited), sets cursor = (0,0) and `move_count = 0`. Next state is S_TRACK. If the clamped size is 1×1, next state is S_DONE instead.
  - **S_TRACK.** On exactly one `*_evt` in a cycle, compute the target cell: up = y-1, down = y+1, left = x-1, right = x+1.
    - If the target is in range (0..w_reg-1, 0..h_reg-1): move the cursor, set `path_data[3*tx+ty]`, and increment `move_count` (saturating).
    - If the target is out of range, ignore the event. No change occurs, including to the count.
    - If two or more direction events occur in the same cycle, ignore all of them.
    - If an accepted move lands on `(w_reg-1, h_reg-1)`, go to S_DONE.
  - **S_DONE.** Direction events are ignored. `done` = 1.
- **Clear.** `clear_evt` in any state forces S_INIT on the next edge and takes priority over direction events. It is the only way to leave S_DONE and the only way to resample the dimensions.
- **Revisits.** Moving into an already-visited cell is allowed. The bit stays 1 and the move is still counted.
- **Unused bits.** Bits for cells outside `w_reg × h_reg` are always 0.

## Timing
- **Reset values** (asserted asynchronously): state = S_INIT, `path_data = 0`, `cur_x = cur_y = 0`, `move_count = 0`, `done = 0`, all synchronizer flops = 0.
  - The first rising `clk` after reset deassertion executes S_INIT, so `path_data = 9'b1` is visible after that edge.
- **Button latency.** A raw button first sampled high at edge N appears in the outputs after edge N+2, i.e. 3 edges in total.
- **Clear latency.** `clear` takes 3 edges to reach the S_INIT transition, plus 1 edge for S_INIT itself.
- **Holding a button.** A held button produces exactly one event. The next event requires the synchronized level to go low and then high again.
- **Output registration.** All outputs are registered. `done` is decoded from the state register.
- **Mid-operation reset.** Asserting reset in any state returns immediately to the reset values above.

## Configuration
- **`PATH_BACKTRACK_EN` defined:** the block keeps previous-cell registers `px`/`py`, which are loaded with the current cell on every accepted move and with (0,0) in S_INIT.
  - An accepted move whose target equals `(px, py)` clears the bit of the cell being left, then moves the cursor.
  - On this backtrack move, `move_count` is decremented instead of incremented, floored at 0.
  - After a backtrack move, `(px, py)` is not restored. A second consecutive reverse move is treated as a normal move.
- **`PATH_BACKTRACK_EN` not defined:** all accepted moves only set bits and only increment the count. The `px`/`py` registers are not built.

## Structure
- **Shared package `maze_pkg`:**
  - Constants: `MAZE_MAX_DIM = 3`, `PATH_W = 9`, `DIM_W = 3`, `POS_W = 2`.
  - FSM state encoding: S_INIT = 2'd0, S_TRACK = 2'd1, S_DONE = 2'd2.
  - Function `cell_idx(x, y) = 3*x + y`, shared with the renderer.
- **Sub-module `btn_edge`:** 2-flop synchronizer plus rising-edge detector, with the same clock and reset. It is instantiated five times: four directions plus `clear`.

## Test plan
- **Reset and start.** Apply reset; release; dims 3×3 → after 1 edge: `path_data = 9'h001`, cursor (0,0), `move_count = 0`, `done = 0`.
- **Snake to goal.** 3×3 grid. Pulses right, right, down, down → `path_data` gets bits 0, 3, 6, 7, 8 set (`9'h1C9`); `move_count = 4`; `done = 1`. A further pulse on `btn_left` has no effect.
- **Out-of-range, simultaneous and held inputs.** 2×2 grid at (0,0):
  - Pulse up → no change (still `9'h001`, count 0).
  - Up and left asserted in the same cycle → no change.
  - Right held high for 10 cycles → exactly one move: `path_data = 9'h009`, count 1.
- **Clamp and clear.** Dims width = 0, height = 5 → treated as 1×3. Pulse down, down → `done = 1`, `path_data = 9'h007`. Pulse `clear` with dims changed to 2×2 → re-init to `9'h001`, count 0, `done = 0`.
- **Backtrack (with `PATH_BACKTRACK_EN`).** Pulse right, then left → `path_data = 9'h001`, count 0. Pulse left again → out of range, ignored.
- **Mid-move reset.** Assert reset 1 edge after a raw button rises → all outputs are 0 immediately, and no move appears after reset is released.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared maze definitions: grid constants, tracker state encoding and the
// cell-to-bit mapping that the VGA renderer also uses.
package maze_pkg;

    localparam int MAZE_MAX_DIM = 3;
    localparam int PATH_W       = 9;
    localparam int DIM_W        = 3;
    localparam int POS_W        = 2;

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_TRACK = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Column-major packing: renderer slices path_array[x][y] from these bits.
    function automatic logic [3:0] cell_idx(input logic [POS_W-1:0] x,
                                            input logic [POS_W-1:0] y);
        return ({2'b00, x} * 4'd3) + {2'b00, y};
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchronizer for a raw asynchronous level followed by a
// rising-edge detector that emits a single-cycle pulse.
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic evt_o
);

    logic sync1_q;
    logic sync2_q;
    logic dly_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
        end
    end

    assign evt_o = sync2_q & ~dly_q;

endmodule

// File: rtl/maze_path_tracker.sv
// Cursor tracker for the maze renderer: marks visited cells and counts moves.
// Optional macro PATH_BACKTRACK_EN: stepping back onto the previous cell erases the cell left.
//
// state   | meaning
// S_INIT  | latch clamped dims, visit (0,0), clear count
// S_TRACK | accept single in-range direction events
// S_DONE  | cursor on goal cell, direction events ignored
module maze_path_tracker
    import maze_pkg::*;
#(
    parameter int MAX_DIM = 3,
    parameter int CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         btn_up,
    input  logic                         btn_down,
    input  logic                         btn_left,
    input  logic                         btn_right,
    input  logic                         clear,
    input  logic [2:0]                   maze_width,
    input  logic [2:0]                   maze_height,
    output logic [MAX_DIM*MAX_DIM-1:0]   path_data,
    output logic [1:0]                   cur_x,
    output logic [1:0]                   cur_y,
    output logic [CNT_W-1:0]             move_count,
    output logic                         done
);

    localparam int PW = MAX_DIM * MAX_DIM;
    localparam logic [DIM_W-1:0] MAX_D = DIM_W'(MAX_DIM);

    logic evt_up;
    logic evt_down;
    logic evt_left;
    logic evt_right;
    logic evt_clear;

    btn_edge u_edge_up    (.clk(clk), .reset(reset), .raw_i(btn_up),    .evt_o(evt_up));
    btn_edge u_edge_down  (.clk(clk), .reset(reset), .raw_i(btn_down),  .evt_o(evt_down));
    btn_edge u_edge_left  (.clk(clk), .reset(reset), .raw_i(btn_left),  .evt_o(evt_left));
    btn_edge u_edge_right (.clk(clk), .reset(reset), .raw_i(btn_right), .evt_o(evt_right));
    btn_edge u_edge_clear (.clk(clk), .reset(reset), .raw_i(clear),     .evt_o(evt_clear));

    function automatic logic [DIM_W-1:0] clamp_dim(input logic [DIM_W-1:0] d);
        if (d == '0) begin
            return DIM_W'(1);
        end else if (d > MAX_D) begin
            return MAX_D;
        end
        return d;
    endfunction

    state_t             state_q, state_d;
    logic [DIM_W-1:0]   w_q, w_d;
    logic [DIM_W-1:0]   h_q, h_d;
    logic [PW-1:0]      path_q, path_d;
    logic [POS_W-1:0]   x_q, x_d;
    logic [POS_W-1:0]   y_q, y_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
`ifdef PATH_BACKTRACK_EN
    logic [POS_W-1:0]   px_q, px_d;
    logic [POS_W-1:0]   py_q, py_d;
    // Cleared by a backtrack so an immediate reverse of it counts as a normal move.
    logic               bt_ok_q, bt_ok_d;
`endif

    logic [2:0]         dir_cnt;
    logic [DIM_W-1:0]   tx;
    logic [DIM_W-1:0]   ty;
    logic               in_range;
    logic               move_ok;

    always_comb begin
        dir_cnt  = 3'(evt_up) + 3'(evt_down) + 3'(evt_left) + 3'(evt_right);
        tx       = {1'b0, x_q};
        ty       = {1'b0, y_q};
        in_range = 1'b0;
        if (evt_up) begin
            in_range = (y_q != '0);
            ty       = {1'b0, y_q} - 3'd1;
        end else if (evt_down) begin
            ty       = {1'b0, y_q} + 3'd1;
            in_range = (ty < h_q);
        end else if (evt_left) begin
            in_range = (x_q != '0);
            tx       = {1'b0, x_q} - 3'd1;
        end else if (evt_right) begin
            tx       = {1'b0, x_q} + 3'd1;
            in_range = (tx < w_q);
        end
        move_ok = (dir_cnt == 3'd1) && in_range;
    end

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        h_d     = h_q;
        path_d  = path_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
`ifdef PATH_BACKTRACK_EN
        px_d    = px_q;
        py_d    = py_q;
        bt_ok_d = bt_ok_q;
`endif
        if (evt_clear) begin
            state_d = S_INIT;
        end else begin
            case (state_q)
                S_INIT: begin
                    w_d    = clamp_dim(maze_width);
                    h_d    = clamp_dim(maze_height);
                    path_d = PW'(1);
                    x_d    = '0;
                    y_d    = '0;
                    cnt_d  = '0;
`ifdef PATH_BACKTRACK_EN
                    px_d    = '0;
                    py_d    = '0;
                    bt_ok_d = 1'b0;
`endif
                    state_d = ((w_d == 3'd1) && (h_d == 3'd1)) ? S_DONE : S_TRACK;
                end
                S_TRACK: begin
                    if (move_ok) begin
                        x_d = tx[POS_W-1:0];
                        y_d = ty[POS_W-1:0];
                        path_d[cell_idx(tx[POS_W-1:0], ty[POS_W-1:0])] = 1'b1;
`ifdef PATH_BACKTRACK_EN
                        if (bt_ok_q && (tx[POS_W-1:0] == px_q) && (ty[POS_W-1:0] == py_q)) begin
                            path_d[cell_idx(x_q, y_q)] = 1'b0;
                            cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CNT_W'(1);
                            bt_ok_d = 1'b0;
                        end else begin
                            cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                            bt_ok_d = 1'b1;
                        end
                        px_d = x_q;
                        py_d = y_q;
`else
                        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
`endif
                        if ((tx == w_q - 3'd1) && (ty == h_q - 3'd1)) begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_INIT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_INIT;
            w_q     <= DIM_W'(1);
            h_q     <= DIM_W'(1);
            path_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
`ifdef PATH_BACKTRACK_EN
            px_q    <= '0;
            py_q    <= '0;
            bt_ok_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            h_q     <= h_d;
            path_q  <= path_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
`ifdef PATH_BACKTRACK_EN
            px_q    <= px_d;
            py_q    <= py_d;
            bt_ok_q <= bt_ok_d;
`endif
        end
    end

    assign path_data  = path_q;
    assign cur_x      = x_q;
    assign cur_y      = y_q;
    assign move_count = cnt_q;
    assign done       = (state_q == S_DONE);

endmodule
